// File: rtl/o_delay_ctrl_pkg.sv
// Shared types and helpers for the O_DELAY tap-control sequencer.
package o_delay_ctrl_pkg;

  localparam int unsigned TAP_W   = 6;
  localparam int unsigned TAP_MAX = 63;
  localparam int unsigned STEP_W  = 7;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_PULSE,
    LOAD_WAIT,
    CMP,
    ADJ_PULSE,
    ADJ_WAIT,
    CHECK
  } state_t;

  // Adjust direction toward the target: 1 = increment.
  function automatic logic next_dir(input logic [TAP_W-1:0] target,
                                    input logic [TAP_W-1:0] tap);
    return target > tap;
  endfunction

endpackage

// File: rtl/o_delay_pulse_timer.sv
// One-cycle pulse generator followed by a SETTLE-1 cycle wait and a done strobe.
// Shared by the load and adjust paths; sel_load routes the pulse.
module o_delay_pulse_timer #(
  parameter int unsigned SETTLE = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic sel_load,
  output logic load_pulse,
  output logic adj_pulse,
  output logic done
);

  logic [3:0] cnt;
  logic       active;

  // Pulse is asserted the cycle after start; cnt holds SETTLE-1 during the
  // pulse and reaches zero on the last wait cycle.
  assign done = active && !(load_pulse || adj_pulse) && (cnt == '0);

  // Pulse outputs and wait counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pulse <= 1'b0;
      adj_pulse  <= 1'b0;
      active     <= 1'b0;
      cnt        <= '0;
    end else begin
      load_pulse <= start && sel_load;
      adj_pulse  <= start && !sel_load;
      if (start) begin
        active <= 1'b1;
        cnt    <= 4'(SETTLE - 1);
      end else if (done) begin
        active <= 1'b0;
      end else if (active && (cnt != '0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: rtl/o_delay_tap_ctrl.sv
// Sequencer that walks an O_DELAY tap to a requested value using DLY_LOAD and
// spaced DLY_ADJ pulses, verifying the readback after every step.
module o_delay_tap_ctrl
  import o_delay_ctrl_pkg::*;
#(
  parameter int unsigned DELAY     = 0,
  parameter int unsigned SETTLE    = 3,
  parameter int unsigned MAX_STEPS = 64
) (
  input  logic              CLK_IN,
  input  logic              RST,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic              REQ_LOAD,
  input  logic [TAP_W-1:0]  REQ_TAP,
  output logic              DONE,
  output logic              ERROR,
  output logic              BUSY,
  output logic              DLY_LOAD,
  output logic              DLY_ADJ,
  output logic              DLY_INCDEC,
  input  logic [TAP_W-1:0]  DLY_TAP_VALUE,
  output logic [STEP_W-1:0] STEP_CNT
);

  if (SETTLE < 3 || SETTLE > 15) begin : g_bad_settle
    $error("o_delay_tap_ctrl: SETTLE must be within 3..15");
  end

  state_t            state, next_state;
  logic [TAP_W-1:0]  target, prev_tap, check_tap;
  logic              accept, tap_eq, load_ok, step_ok, steps_exhausted;
  logic              tmr_start, tmr_sel, tmr_done;
  logic              ready_d, busy_d, done_d, err_d, incdec_d;
  logic [STEP_W-1:0] step_d;

  assign accept          = REQ_VALID && REQ_READY;
  assign tap_eq          = (DLY_TAP_VALUE == target);
  assign load_ok         = (DLY_TAP_VALUE == TAP_W'(DELAY));
  assign check_tap       = DLY_INCDEC ? prev_tap + TAP_W'(1) : prev_tap - TAP_W'(1);
  assign step_ok         = (DLY_TAP_VALUE == check_tap);
  assign steps_exhausted = (STEP_CNT == STEP_W'(MAX_STEPS));

  // Pulse states last one cycle, so entering one is a clean timer start.
  assign tmr_start = (next_state == LOAD_PULSE) || (next_state == ADJ_PULSE);
  assign tmr_sel   = (next_state == LOAD_PULSE);

  o_delay_pulse_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk       (CLK_IN),
    .rst_n     (RST),
    .start     (tmr_start),
    .sel_load  (tmr_sel),
    .load_pulse(DLY_LOAD),
    .adj_pulse (DLY_ADJ),
    .done      (tmr_done)
  );

  // State register.
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decision.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:       if (accept) next_state = REQ_LOAD ? LOAD_PULSE : CMP;
      LOAD_PULSE: next_state = LOAD_WAIT;
      LOAD_WAIT:  if (tmr_done) next_state = load_ok ? CMP : IDLE;
      CMP: begin
        if (tap_eq || steps_exhausted) next_state = IDLE;
        else                           next_state = ADJ_PULSE;
      end
      ADJ_PULSE:  next_state = ADJ_WAIT;
      ADJ_WAIT:   if (tmr_done) next_state = CHECK;
      CHECK:      next_state = step_ok ? CMP : IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Next values of the registered status outputs, derived from the transition.
  always_comb begin
    ready_d  = (next_state == IDLE);
    busy_d   = (next_state != IDLE);
    done_d   = (state == CMP) && tap_eq;
    incdec_d = DLY_INCDEC;
    step_d   = STEP_CNT;
    err_d    = ERROR;
    if (accept) begin
      err_d  = 1'b0;
      step_d = '0;
    end
    if ((state == LOAD_WAIT && tmr_done && !load_ok) ||
        (state == CMP && !tap_eq && steps_exhausted) ||
        (state == CHECK && !step_ok))
      err_d = 1'b1;
    if (state == CMP && next_state == ADJ_PULSE) begin
      incdec_d = next_dir(target, DLY_TAP_VALUE);
      if (STEP_CNT != '1) step_d = STEP_CNT + STEP_W'(1);
    end
  end

  // Registered status outputs.
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      REQ_READY  <= 1'b0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERROR      <= 1'b0;
      DLY_INCDEC <= 1'b0;
      STEP_CNT   <= '0;
    end else begin
      REQ_READY  <= ready_d;
      BUSY       <= busy_d;
      DONE       <= done_d;
      ERROR      <= err_d;
      DLY_INCDEC <= incdec_d;
      STEP_CNT   <= step_d;
    end
  end

  // Request target and the tap seen before each adjust pulse.
  always_ff @(posedge CLK_IN or negedge RST) begin
    if (!RST) begin
      target   <= '0;
      prev_tap <= '0;
    end else begin
      if (accept)        target   <= REQ_TAP;
      if (state == CMP)  prev_tap <= DLY_TAP_VALUE;
    end
  end

endmodule

// File: tb/tb_o_delay_tap_ctrl.sv
// Scoreboard bench for o_delay_tap_ctrl paired with a behavioural O_DELAY.
module tb_o_delay_tap_ctrl;
  import o_delay_ctrl_pkg::*;

  localparam int unsigned DELAY     = 0;
  localparam int unsigned SETTLE    = 3;
  localparam int unsigned MAX_STEPS = 64;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_load;
  logic [5:0] req_tap;
  logic       done, error, busy, dly_load, dly_adj, dly_incdec;
  logic [5:0] tap_value;
  logic [6:0] step_cnt;

  always #5 clk = ~clk;

  o_delay_tap_ctrl #(
    .DELAY    (DELAY),
    .SETTLE   (SETTLE),
    .MAX_STEPS(MAX_STEPS)
  ) dut (
    .CLK_IN       (clk),
    .RST          (rst_n),
    .REQ_VALID    (req_valid),
    .REQ_READY    (req_ready),
    .REQ_LOAD     (req_load),
    .REQ_TAP      (req_tap),
    .DONE         (done),
    .ERROR        (error),
    .BUSY         (busy),
    .DLY_LOAD     (dly_load),
    .DLY_ADJ      (dly_adj),
    .DLY_INCDEC   (dly_incdec),
    .DLY_TAP_VALUE(tap_value),
    .STEP_CNT     (step_cnt)
  );

  // Behavioural O_DELAY: pins registered once and edge-detected, so the tap
  // moves two edges after the pulse-assert edge; INCDEC sampled at that edge.
  logic [5:0] m_tap  = 6'd0;
  logic       adj_q  = 1'b0, adj_qq = 1'b0, ld_q = 1'b0, ld_qq = 1'b0;
  bit         stuck  = 1'b0;

  always @(posedge clk) begin
    adj_q  <= dly_adj;
    adj_qq <= adj_q;
    ld_q   <= dly_load;
    ld_qq  <= ld_q;
    if (ld_q && !ld_qq)        m_tap <= 6'(DELAY);
    else if (adj_q && !adj_qq) m_tap <= dly_incdec ? m_tap + 6'd1 : m_tap - 6'd1;
  end

  assign tap_value = stuck ? 6'd7 : m_tap;

  typedef struct {
    bit done;
    bit err;
    int steps;
    int tap;
    int lat;
    int loads;
    int inc;
    int dec;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cur_tap = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Monitor state
  int cyc = 0;
  bit busy_p = 1'b0, adj_p = 1'b0, ld_p = 1'b0;
  int c_start = 0, n_adj = 0, n_adj_hi = 0, n_ld = 0, n_inc = 0, n_dec = 0;
  int last_adj = 0, min_gap = 1000, rdy_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy_p = 1'b0;
      adj_p  = 1'b0;
      ld_p   = 1'b0;
    end else begin
      if (busy && !busy_p) begin
        c_start  = cyc;
        n_adj    = 0;
        n_adj_hi = 0;
        n_ld     = 0;
        n_inc    = 0;
        n_dec    = 0;
        min_gap  = 1000;
      end
      if (busy && req_ready) rdy_viol++;
      if (dly_adj) n_adj_hi++;
      if (dly_adj && !adj_p) begin
        if (n_adj > 0 && (cyc - last_adj) < min_gap) min_gap = cyc - last_adj;
        last_adj = cyc;
        n_adj++;
        if (dly_incdec) n_inc++;
        else            n_dec++;
      end
      if (dly_load && !ld_p) n_ld++;
      if (!busy && busy_p) begin
        if (sb.size() == 0) begin
          check("unexpected_completion", 1, 0);
        end else begin
          mon_e = sb.pop_front();
          check("done",       done,          mon_e.done);
          check("error",      error,         mon_e.err);
          check("step_cnt",   step_cnt,      mon_e.steps);
          check("tap",        tap_value,     mon_e.tap);
          check("latency",    cyc - c_start, mon_e.lat);
          check("adj_pulses", n_adj,         mon_e.steps);
          check("adj_width",  n_adj_hi,      mon_e.steps);
          check("load_pulses", n_ld,         mon_e.loads);
          check("inc_pulses", n_inc,         mon_e.inc);
          check("dec_pulses", n_dec,         mon_e.dec);
          check("pulse_gap_ok", int'(min_gap >= int'(SETTLE)), 1);
        end
      end
      busy_p = busy;
      adj_p  = dly_adj;
      ld_p   = dly_load;
    end
  end

  function automatic exp_t make_exp(input int tgt, input bit load);
    exp_t e;
    int   start, n;
    start   = load ? int'(DELAY) : cur_tap;
    n       = (tgt > start) ? tgt - start : start - tgt;
    e.done  = 1'b1;
    e.err   = 1'b0;
    e.steps = n;
    e.tap   = tgt;
    e.lat   = (load ? int'(SETTLE) : 0) + n * (int'(SETTLE) + 2) + 1;
    e.loads = load ? 1 : 0;
    e.inc   = (tgt > start) ? n : 0;
    e.dec   = (tgt < start) ? n : 0;
    return e;
  endfunction

  task automatic wait_ready();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (req_ready) return;
    end
    check("ready_timeout", 0, 1);
  endtask

  task automatic send(input int tgt, input bit load);
    wait_ready();
    req_valid = 1'b1;
    req_tap   = 6'(tgt);
    req_load  = load;
    sb.push_back(make_exp(tgt, load));
    cur_tap   = tgt;
    @(negedge clk);
    req_valid = 1'b0;
    req_load  = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) return;
    end
    check("completion_timeout", sb.size(), 0);
    sb.delete();
  endtask

  exp_t e_stuck;
  bit   found;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_load  = 1'b0;
    req_tap   = 6'd0;
    repeat (3) @(negedge clk);
    check("rst_done",     done,       0);
    check("rst_error",    error,      0);
    check("rst_busy",     busy,       0);
    check("rst_dly_load", dly_load,   0);
    check("rst_dly_adj",  dly_adj,    0);
    check("rst_incdec",   dly_incdec, 0);
    check("rst_step_cnt", step_cnt,   0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", req_ready, 1);

    // Load then seek upward
    send(5, 1'b1);
    wait_idle();
    // Seek downward
    send(2, 1'b0);
    wait_idle();
    // Already at target
    send(2, 1'b0);
    wait_idle();
    // Top of range
    send(60, 1'b0);
    wait_idle();
    send(63, 1'b0);
    wait_idle();
    send(63, 1'b0);
    wait_idle();

    // Request held through BUSY with a different second target
    wait_ready();
    req_valid = 1'b1;
    req_tap   = 6'd15;
    req_load  = 1'b0;
    sb.push_back(make_exp(15, 1'b0));
    cur_tap   = 15;
    @(negedge clk);
    req_tap = 6'd10;
    sb.push_back(make_exp(10, 1'b0));
    cur_tap = 10;
    repeat (4) @(negedge clk);
    check("ready_low_while_busy", req_ready, 0);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (sb.size() <= 1 && busy) break;
    end
    req_valid = 1'b0;
    wait_idle();
    check("ready_while_busy_count", rdy_viol, 0);

    // Readback stuck at 7: first CHECK fails
    stuck = 1'b1;
    wait_ready();
    req_valid     = 1'b1;
    req_tap       = 6'd9;
    req_load      = 1'b0;
    e_stuck.done  = 1'b0;
    e_stuck.err   = 1'b1;
    e_stuck.steps = 1;
    e_stuck.tap   = 7;
    e_stuck.lat   = int'(SETTLE) + 2;
    e_stuck.loads = 0;
    e_stuck.inc   = 1;
    e_stuck.dec   = 0;
    sb.push_back(e_stuck);
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    check("error_sticky", error, 1);
    check("no_done_after_error", done, 0);
    stuck = 1'b0;

    // New request clears ERROR
    send(12, 1'b1);
    check("error_cleared_on_accept", error, 0);
    wait_idle();

    // Reset during ADJ_WAIT
    wait_ready();
    req_valid = 1'b1;
    req_tap   = 6'd30;
    req_load  = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dly_adj) begin
        found = 1'b1;
        break;
      end
    end
    check("adj_seen_before_reset", int'(found), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",     busy,     0);
    check("midrst_dly_adj",  dly_adj,  0);
    check("midrst_dly_load", dly_load, 0);
    check("midrst_done",     done,     0);
    check("midrst_error",    error,    0);
    check("midrst_step_cnt", step_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_midrst", req_ready, 1);
    check("busy_after_midrst",  busy,      0);

    // Recovery after reset
    send(3, 1'b1);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
